demux4_tdm: RTL and testbench
=============================

DEMUX4_TDM -- requirements
Module: demux4_tdm

Interface
REQ-001 Parameter: W, default 4, data width of each channel.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 DIN  input  W  time-multiplexed data word.
REQ-005 VALID  input  1  DIN carries a word this cycle.
REQ-006 SOF  input  1  start of frame; qualified by VALID; marks the slot-0 word.
REQ-007 CH0, CH1, CH2, CH3  output  W each  demultiplexed channel registers.
REQ-008 SEL  output  2  slot index the next accepted word will be written to.
REQ-009 FRAME_DONE  output  1  one-cycle pulse after the slot-3 word is accepted.
REQ-010 ERR  output  1  one-cycle pulse on a framing error.

Function
REQ-011 Two states SHALL be used: IDLE (no frame in progress) and RECV (frame in progress).
- Accepted word: any cycle with VALID=1.
REQ-012 In IDLE, a word with SOF=0 SHALL be ignored; no outputs change.
REQ-013 In IDLE, a word with SOF=1 SHALL be written to slot 0; SEL becomes 1; state becomes RECV.
REQ-014 In RECV, a word with SOF=0 SHALL be written to slot SEL; SEL increments by 1.
REQ-015 The slot-3 word SHALL wrap SEL to 0, return to IDLE, and pulse FRAME_DONE high in the following cycle.
REQ-016 In RECV, a word with SOF=1 (early SOF) SHALL abandon the partial frame.
- That word is written to slot 0; SEL becomes 1; state stays RECV.
- ERR pulses high in the following cycle.
- No FRAME_DONE is issued for the abandoned frame.
REQ-017 Cycles with VALID=0 SHALL hold all state, including mid-frame; there is no timeout.
REQ-018 Latency: a word accepted on edge N SHALL be visible on its CH output after edge N (direct mode) or after edge N of the slot-3 word (hold mode, see Configuration).
REQ-019 FRAME_DONE and ERR SHALL never be high in the same cycle.
REQ-020 SEL SHALL be 0 whenever the state is IDLE.

Reset
REQ-021 RST_N low SHALL immediately force the following, independent of CLK:
- state IDLE, SEL=0;
- CH0..CH3 = 0, with any hold buffer also 0;
- FRAME_DONE=0, ERR=0.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame without raising ERR.
REQ-023 After RST_N deasserts, the first accepted word SHALL be evaluated in IDLE.

Configuration
REQ-024 Macro DEMUX4_TDM_HOLD_EN selects the output update mode.
REQ-025 With DEMUX4_TDM_HOLD_EN defined (hold mode):
- words land in an internal 4-slot shadow buffer;
- CH0..CH3 load all four slots at once on the edge accepting the slot-3 word;
- an abandoned frame never reaches CH outputs.
REQ-026 Without DEMUX4_TDM_HOLD_EN (direct mode):
- each word writes its CH register directly on acceptance;
- no shadow buffer exists;
- an abandoned frame leaves its partial writes visible.

Verification
REQ-027 Reset-only check: assert RST_N=0 with no clock edges -> CH0..CH3=0, SEL=0, FRAME_DONE=0, ERR=0 immediately.
REQ-028 Full frame: words 1,2,3,4 (SOF on 1), VALID continuous -> CH0..CH3 = 1,2,3,4; one FRAME_DONE pulse; SEL=0; ERR never high.
REQ-029 Gapped frame: same data with VALID=0 for 3 cycles between words 2 and 3 -> same result; SEL holds at 2 during the gap.
REQ-030 Early SOF: words 5,6 (SOF on 5), then 9(SOF),A,B,C ->
- ERR pulses once; one FRAME_DONE pulse;
- final CH0..CH3 = 9,A,B,C;
- in hold mode CH0 never shows 5 and CH1 never shows 6.
REQ-031 Idle noise: three words with SOF=0 after reset -> CH outputs stay 0; SEL=0; no pulses.
REQ-032 Reset mid-frame: assert RST_N after 2 words of a frame, then send a full frame 7,8,9,A -> CH0..CH3 = 7,8,9,A; ERR never high.

Source files
------------

// File: rtl/demux4_tdm_if.sv
// demux4_tdm_if -- bundle of the time-multiplexed input stream and the four
// demultiplexed channel outputs of demux4_tdm.
//   master : source side. Drives din/valid/sof and observes the channel outputs.
//   slave  : the demultiplexer. Receives din/valid/sof and drives ch0..ch3,
//            sel, frame_done and err.
// Parameter W is the width of each data word and channel register.
interface demux4_tdm_if #(
  parameter int W = 4
);
  logic [W-1:0] din;
  logic         valid;
  logic         sof;
  logic [W-1:0] ch0;
  logic [W-1:0] ch1;
  logic [W-1:0] ch2;
  logic [W-1:0] ch3;
  logic [1:0]   sel;
  logic         frame_done;
  logic         err;

  modport master (
    output din, valid, sof,
    input  ch0, ch1, ch2, ch3, sel, frame_done, err
  );

  modport slave (
    input  din, valid, sof,
    output ch0, ch1, ch2, ch3, sel, frame_done, err
  );
endinterface

// File: rtl/demux4_tdm.sv
// demux4_tdm -- four-slot time-division demultiplexer.
// Words arriving on bus.din with bus.valid are distributed to ch0..ch3 in
// frame order; bus.sof marks the slot-0 word of each frame.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears state, channels, pulses)
//   bus    : demux4_tdm_if.slave
//            din/valid/sof in; ch0..ch3, sel, frame_done, err out.
//            sel        : slot the next accepted word will be written to
//            frame_done : one-cycle pulse after the slot-3 word is accepted
//            err        : one-cycle pulse after an early SOF abandons a frame
// Build option:
//   DEMUX4_TDM_HOLD_EN defined -> hold mode: words collect in a shadow buffer
//   and all four channels update together when the slot-3 word arrives.
//   Undefined (default)        -> direct mode: each word writes its channel
//   register as soon as it is accepted.
module demux4_tdm #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  demux4_tdm_if.slave      bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]   state;
  logic [1:0]   sel;
  logic         frame_done;
  logic         err;
  logic [W-1:0] ch [4];

  logic         wr_en;
  logic [1:0]   wr_slot;
  logic         last;

  // A word is stored if it starts a frame or continues one; SOF always
  // restarts at slot 0, even mid-frame.
  assign wr_en   = bus.valid && (bus.sof || (state == RECV));
  assign wr_slot = bus.sof ? 2'd0 : sel;
  assign last    = bus.valid && !bus.sof && (state == RECV) && (sel == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 2'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (bus.valid) begin
        if (bus.sof) begin
          // Early SOF abandons the partial frame without a frame_done.
          err   <= (state == RECV);
          state <= RECV;
          sel   <= 2'd1;
        end else if (state == RECV) begin
          if (last) begin
            state      <= IDLE;
            sel        <= 2'd0;
            frame_done <= 1'b1;
          end else begin
            sel <= sel + 2'd1;
          end
        end
      end
    end
  end

`ifdef DEMUX4_TDM_HOLD_EN
  logic [W-1:0] shadow [4];

  // Only slots 0..2 are read back from the shadow; the slot-3 word goes
  // straight to ch[3] on the same edge, so an abandoned frame never escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
        ch[i]     <= '0;
      end
    end else begin
      if (wr_en) begin
        shadow[wr_slot] <= bus.din;
      end
      if (last) begin
        ch[0] <= shadow[0];
        ch[1] <= shadow[1];
        ch[2] <= shadow[2];
        ch[3] <= bus.din;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        ch[i] <= '0;
      end
    end else if (wr_en) begin
      ch[wr_slot] <= bus.din;
    end
  end
`endif

  assign bus.ch0        = ch[0];
  assign bus.ch1        = ch[1];
  assign bus.ch2        = ch[2];
  assign bus.ch3        = ch[3];
  assign bus.sel        = sel;
  assign bus.frame_done = frame_done;
  assign bus.err        = err;

endmodule

// File: tb/tb_demux4_tdm.sv
// tb_demux4_tdm -- self-checking bench for demux4_tdm.
// Directed frame scenarios followed by randomized traffic, all checked every
// cycle against a queue-based frame model. Honours DEMUX4_TDM_HOLD_EN.
module tb_demux4_tdm;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  demux4_tdm_if #(.W(W)) bus ();

  demux4_tdm #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the words of the frame in progress, plus the channel
  // values the outside world should currently see.
  logic [W-1:0] m_part [$];
  logic [W-1:0] m_ch [4];
  logic         m_done;
  logic         m_err;

  int n_done;
  int n_err;
  int seen_abandoned;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ch0"}, 32'(bus.ch0), 32'(m_ch[0]));
    check({tag, ".ch1"}, 32'(bus.ch1), 32'(m_ch[1]));
    check({tag, ".ch2"}, 32'(bus.ch2), 32'(m_ch[2]));
    check({tag, ".ch3"}, 32'(bus.ch3), 32'(m_ch[3]));
    check({tag, ".sel"}, 32'(bus.sel), 32'(m_part.size() % 4));
    check({tag, ".frame_done"}, 32'(bus.frame_done), 32'(m_done));
    check({tag, ".err"}, 32'(bus.err), 32'(m_err));
    check({tag, ".pulse_excl"}, 32'(bus.frame_done & bus.err), 32'd0);
  endtask

  task automatic model_reset();
    m_part.delete();
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic v, input logic s);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (v) begin
      if (s) begin
        if (m_part.size() > 0) m_err = 1'b1;
        m_part.delete();
        m_part.push_back(d);
`ifndef DEMUX4_TDM_HOLD_EN
        m_ch[0] = d;
`endif
      end else if (m_part.size() > 0) begin
        m_part.push_back(d);
`ifndef DEMUX4_TDM_HOLD_EN
        m_ch[m_part.size() - 1] = d;
`endif
        if (m_part.size() == 4) begin
`ifdef DEMUX4_TDM_HOLD_EN
          for (int i = 0; i < 4; i++) m_ch[i] = m_part[i];
`endif
          m_done = 1'b1;
          m_part.delete();
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic step(input string tag, input logic [W-1:0] d, input logic v, input logic s);
    bus.din   = d;
    bus.valid = v;
    bus.sof   = s;
    @(posedge clk);
    model_accept(d, v, s);
    #1;
    if (bus.frame_done) n_done++;
    if (bus.err) n_err++;
    if (bus.ch0 == W'(5) || bus.ch1 == W'(6)) seen_abandoned++;
    check_all(tag);
  endtask

  // Asynchronous reset between edges; outputs are checked before any clock edge.
  task automatic do_reset(input string tag);
    bus.valid = 1'b0;
    bus.sof   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 rst_n = 1'b1;
    n_done = 0;
    n_err  = 0;
    seen_abandoned = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_done   = 0;
    n_err    = 0;
    seen_abandoned = 0;
    rst_n     = 1'b1;
    bus.din   = '0;
    bus.valid = 1'b0;
    bus.sof   = 1'b0;
    model_reset();

    // Reset with no clock edge yet.
    #2 rst_n = 1'b0;
    #1 check_all("reset_only");
    rst_n = 1'b1;

    // Full frame, continuous valid.
    step("full", 4'h1, 1'b1, 1'b1);
    step("full", 4'h2, 1'b1, 1'b0);
    step("full", 4'h3, 1'b1, 1'b0);
    step("full", 4'h4, 1'b1, 1'b0);
    step("full", 4'h0, 1'b0, 1'b0);
    check("full.ch_final", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'h1234);
    check("full.done_cnt", n_done, 1);
    check("full.err_cnt", n_err, 0);

    // Gapped frame: sel must hold at 2 across the gap.
    do_reset("rst_gap");
    step("gap", 4'h1, 1'b1, 1'b1);
    step("gap", 4'h2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("gap_idle", 4'hF, 1'b0, 1'b1);
      check("gap.sel_hold", 32'(bus.sel), 32'd2);
    end
    step("gap", 4'h3, 1'b1, 1'b0);
    step("gap", 4'h4, 1'b1, 1'b0);
    step("gap", 4'h0, 1'b0, 1'b0);
    check("gap.ch_final", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'h1234);
    check("gap.done_cnt", n_done, 1);
    check("gap.err_cnt", n_err, 0);

    // Early SOF abandons 5,6.
    do_reset("rst_early");
    step("early", 4'h5, 1'b1, 1'b1);
    step("early", 4'h6, 1'b1, 1'b0);
    step("early", 4'h9, 1'b1, 1'b1);
    step("early", 4'hA, 1'b1, 1'b0);
    step("early", 4'hB, 1'b1, 1'b0);
    step("early", 4'hC, 1'b1, 1'b0);
    step("early", 4'h0, 1'b0, 1'b0);
    check("early.ch_final", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'h9ABC);
    check("early.err_cnt", n_err, 1);
    check("early.done_cnt", n_done, 1);
`ifdef DEMUX4_TDM_HOLD_EN
    check("early.abandoned_hidden", seen_abandoned, 0);
`endif

    // Idle noise after reset.
    do_reset("rst_noise");
    step("noise", 4'h7, 1'b1, 1'b0);
    step("noise", 4'h3, 1'b1, 1'b0);
    step("noise", 4'hE, 1'b1, 1'b0);
    check("noise.ch_final", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'h0000);
    check("noise.pulses", n_done + n_err, 0);

    // Reset mid-frame, then a full frame.
    do_reset("rst_mid_pre");
    step("mid", 4'h3, 1'b1, 1'b1);
    step("mid", 4'h4, 1'b1, 1'b0);
    do_reset("rst_mid");
    step("mid", 4'h7, 1'b1, 1'b1);
    step("mid", 4'h8, 1'b1, 1'b0);
    step("mid", 4'h9, 1'b1, 1'b0);
    step("mid", 4'hA, 1'b1, 1'b0);
    step("mid", 4'h0, 1'b0, 1'b0);
    check("mid.ch_final", {bus.ch0, bus.ch1, bus.ch2, bus.ch3}, 32'h789A);
    check("mid.err_cnt", n_err, 0);
    check("mid.done_cnt", n_done, 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", W'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
